// File: rtl/switch_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : switch_step_controller
// Description : Debounces four command switches and turns one clean press
//               into exactly one step request for a downstream state
//               register. The request is held until acknowledged, then the
//               block waits for a full release before accepting a new press.
//               A press with more than one switch down is reported on
//               multi_err instead of issuing a step.
//
// Ports       : clk         system clock, rising edge
//               reset       synchronous, active-high reset
//               sw[3:0]     raw switch levels, already synchronised to clk
//               step_ack    downstream accepts the pending step this cycle
//               step_valid  step request pending (held until acknowledged)
//               step_code   encoded command: sw[0]->00 .. sw[3]->11
//               multi_err   one-cycle pulse: several switches stable at accept
//               busy        high whenever the FSM is not idle
//               step_count  acknowledged steps, modulo 256
//               state_dbg   IDLE=00, DEBOUNCE=01, ISSUE=10, WAIT_RELEASE=11
//
// Revision    : 1.0  initial release
// ============================================================================
module switch_step_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RELEASE_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       step_ack,
    output logic       step_valid,
    output logic [1:0] step_code,
    output logic       multi_err,
    output logic       busy,
    output logic [7:0] step_count,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_DEBOUNCE     = 2'b01,
        ST_ISSUE        = 2'b10,
        ST_WAIT_RELEASE = 2'b11
    } state_t;

    // Terminal counter values: the counter starts at zero on the first
    // qualifying cycle, so the last qualifying cycle sees N-1.
    localparam logic [15:0] c_deb_last = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_rel_last = 16'(RELEASE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [15:0] w_count_next;
    logic [3:0]  r_sample;
    logic [3:0]  w_sample_next;
    logic [1:0]  r_step_code;
    logic [1:0]  w_step_code_next;
    logic        r_multi_err;
    logic        w_multi_err_next;
    logic [7:0]  r_step_count;
    logic [7:0]  w_step_count_next;
    logic        r_step_valid;
    logic        r_busy;

    logic        w_sample_onehot;
    logic [1:0]  w_sample_code;

    // A sample is one-hot when it is nonzero and clearing its lowest set
    // bit leaves nothing behind.
    assign w_sample_onehot = (r_sample != 4'b0000) &&
                             ((r_sample & (r_sample - 4'd1)) == 4'b0000);

    always_comb begin
        w_sample_code = 2'b00;
        case (r_sample)
            4'b0001: w_sample_code = 2'b00;
            4'b0010: w_sample_code = 2'b01;
            4'b0100: w_sample_code = 2'b10;
            4'b1000: w_sample_code = 2'b11;
            default: w_sample_code = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_sample_next     = r_sample;
        w_step_code_next  = r_step_code;
        w_multi_err_next  = 1'b0;
        w_step_count_next = r_step_count;

        case (r_state)
            ST_IDLE: begin
                if (sw != 4'b0000) begin
                    w_sample_next = sw;
                    w_count_next  = 16'd0;
                    w_state_next  = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (sw != r_sample) begin
                    // Any change during the stability window abandons the
                    // press silently; a still-pressed switch re-enters
                    // from IDLE on the next edge.
                    w_state_next = ST_IDLE;
                end else if (r_count == c_deb_last) begin
                    w_count_next = 16'd0;
                    if (w_sample_onehot) begin
                        w_step_code_next = w_sample_code;
                        w_state_next     = ST_ISSUE;
                    end else begin
                        w_multi_err_next = 1'b1;
                        w_state_next     = ST_WAIT_RELEASE;
                    end
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end

            ST_ISSUE: begin
                // step_code is frozen here; sw is not looked at.
                if (step_ack) begin
                    w_step_count_next = r_step_count + 8'd1;
                    w_count_next      = 16'd0;
                    w_state_next      = ST_WAIT_RELEASE;
                end
            end

            ST_WAIT_RELEASE: begin
                // Any switch activity restarts the release window, so a
                // held or bouncing switch can never produce a second step.
                if (sw != 4'b0000) begin
                    w_count_next = 16'd0;
                end else if (r_count == c_rel_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count + 16'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Flag outputs are derived from the next
    // state so they line up with state_dbg while remaining flop outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= 16'd0;
            r_sample     <= 4'b0000;
            r_step_code  <= 2'b00;
            r_multi_err  <= 1'b0;
            r_step_count <= 8'd0;
            r_step_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_sample     <= w_sample_next;
            r_step_code  <= w_step_code_next;
            r_multi_err  <= w_multi_err_next;
            r_step_count <= w_step_count_next;
            r_step_valid <= (w_state_next == ST_ISSUE);
            r_busy       <= (w_state_next != ST_IDLE);
        end
    end

    assign step_valid = r_step_valid;
    assign step_code  = r_step_code;
    assign multi_err  = r_multi_err;
    assign busy       = r_busy;
    assign step_count = r_step_count;
    assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_switch_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_step_controller
// Description : Self-checking bench for switch_step_controller with
//               DEBOUNCE_CYCLES=4 and RELEASE_CYCLES=3. Directed stimulus
//               pushes expected output events into a queue; a monitor pops
//               and compares whenever step_valid rises or multi_err pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_switch_step_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       step_ack;
    logic       step_valid;
    logic [1:0] step_code;
    logic       multi_err;
    logic       busy;
    logic [7:0] step_count;
    logic [1:0] state_dbg;

    switch_step_controller #(
        .DEBOUNCE_CYCLES (4),
        .RELEASE_CYCLES  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .step_ack   (step_ack),
        .step_valid (step_valid),
        .step_code  (step_code),
        .multi_err  (multi_err),
        .busy       (busy),
        .step_count (step_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_multi;
        logic [1:0] code;
        logic [7:0] count;
        int         edge_no;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  edge_n   = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, edge_n);
    endtask

    task automatic drive(input logic [3:0] s, input logic a, input int n);
        for (int i = 0; i < n; i++) begin
            sw       = s;
            step_ack = a;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_step(input logic [1:0] code, input logic [7:0] cnt, input int at);
        exp_q.push_back('{1'b0, code, cnt, at});
    endtask

    task automatic expect_multi(input logic [7:0] cnt, input int at);
        exp_q.push_back('{1'b1, 2'b00, cnt, at});
    endtask

    // Monitor: an output event is a rising step_valid or a multi_err pulse.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        ev_t ev;
        if ((step_valid && !prev_valid) || multi_err) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got valid=%0b multi=%0b code=%0d at edge %0d, required no event",
                         step_valid, multi_err, step_code, edge_n);
            end else begin
                ev = exp_q.pop_front();
                chk("event_kind", 32'(multi_err), 32'(ev.is_multi));
                chk("event_edge", 32'(edge_n), 32'(ev.edge_no));
                chk("event_count", 32'(step_count), 32'(ev.count));
                if (ev.is_multi) chk("multi_no_valid", 32'(step_valid), 32'd0);
                else             chk("event_code", 32'(step_code), 32'(ev.code));
            end
        end
        prev_valid = step_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [3:0] s;
        sw       = 4'b0000;
        step_ack = 1'b0;
        reset    = 1'b1;

        // Reset with switch and ack activity present
        drive(4'b0101, 1'b1, 2);
        chk("reset_valid",  32'(step_valid), 32'd0);
        chk("reset_code",   32'(step_code),  32'd0);
        chk("reset_multi",  32'(multi_err),  32'd0);
        chk("reset_busy",   32'(busy),       32'd0);
        chk("reset_count",  32'(step_count), 32'd0);
        chk("reset_state",  32'(state_dbg),  32'd0);
        reset = 1'b0;
        drive(4'b0000, 1'b0, 1);

        // Clean press: valid after edge 5, ack at edge 6, 3 zeros to idle
        base = edge_n;
        expect_step(2'b10, 8'd0, base + 5);
        drive(4'b0100, 1'b0, 5);
        chk("clean_valid",      32'(step_valid), 32'd1);
        chk("clean_state",      32'(state_dbg),  32'd2);
        drive(4'b0100, 1'b1, 1);
        chk("clean_valid_drop", 32'(step_valid), 32'd0);
        chk("clean_count",      32'(step_count), 32'd1);
        chk("clean_wait",       32'(state_dbg),  32'd3);
        drive(4'b0000, 1'b1, 2);
        chk("clean_still_wait", 32'(state_dbg),  32'd3);
        drive(4'b0000, 1'b1, 1);
        chk("clean_idle",       32'(state_dbg),  32'd0);
        chk("clean_busy",       32'(busy),       32'd0);
        chk("clean_code_hold",  32'(step_code),  32'd2);
        chk("clean_ack_ignored",32'(step_count), 32'd1);

        // Bounce: 2 on, 1 off, then held; valid 5 edges after re-press
        base = edge_n;
        expect_step(2'b01, 8'd1, base + 8);
        drive(4'b0010, 1'b0, 2);
        drive(4'b0000, 1'b0, 1);
        chk("bounce_idle",  32'(state_dbg),  32'd0);
        drive(4'b0010, 1'b0, 4);
        chk("bounce_early", 32'(step_valid), 32'd0);
        drive(4'b0010, 1'b0, 1);
        chk("bounce_valid", 32'(step_valid), 32'd1);
        drive(4'b0010, 1'b1, 1);
        drive(4'b0000, 1'b0, 3);
        chk("bounce_count", 32'(step_count), 32'd2);
        chk("bounce_idle2", 32'(state_dbg),  32'd0);

        // Multi-press: error pulse after edge 5, no step
        base = edge_n;
        expect_multi(8'd2, base + 5);
        drive(4'b1001, 1'b1, 6);
        chk("multi_valid", 32'(step_valid), 32'd0);
        chk("multi_count", 32'(step_count), 32'd2);
        chk("multi_state", 32'(state_dbg),  32'd3);
        chk("multi_pulse", 32'(multi_err),  32'd0);
        drive(4'b0000, 1'b0, 3);
        chk("multi_idle",  32'(state_dbg),  32'd0);

        // Hold with backpressure: 50 cycles held, ack after 10 stalled cycles
        base = edge_n;
        expect_step(2'b00, 8'd2, base + 5);
        drive(4'b0001, 1'b0, 15);
        chk("hold_valid",      32'(step_valid), 32'd1);
        chk("hold_code",       32'(step_code),  32'd0);
        chk("hold_state",      32'(state_dbg),  32'd2);
        chk("hold_count",      32'(step_count), 32'd2);
        drive(4'b0001, 1'b1, 1);
        chk("hold_valid_drop", 32'(step_valid), 32'd0);
        chk("hold_count_ack",  32'(step_count), 32'd3);
        drive(4'b0001, 1'b1, 34);
        chk("hold_wait",       32'(state_dbg),  32'd3);
        chk("hold_one_step",   32'(step_count), 32'd3);
        drive(4'b0000, 1'b0, 2);
        chk("hold_wait2",      32'(state_dbg),  32'd3);
        drive(4'b0000, 1'b0, 1);
        chk("hold_idle",       32'(state_dbg),  32'd0);

        // Wrap: 256 acknowledged steps from reset
        reset = 1'b1;
        drive(4'b0000, 1'b0, 1);
        reset = 1'b0;
        chk("wrap_start", 32'(step_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            s    = 4'b0001 << i[1:0];
            base = edge_n;
            expect_step(i[1:0], i[7:0], base + 5);
            drive(s, 1'b1, 6);
            drive(4'b0000, 1'b1, 3);
            if (i == 254) chk("wrap_255", 32'(step_count), 32'd255);
        end
        chk("wrap_zero", 32'(step_count), 32'd0);

        // Reset in ISSUE with ack high, switch still held afterwards
        base = edge_n;
        expect_step(2'b11, 8'd0, base + 5);
        drive(4'b1000, 1'b0, 5);
        chk("rst_issue_valid", 32'(step_valid), 32'd1);
        reset = 1'b1;
        drive(4'b1000, 1'b1, 1);
        chk("rst_issue_vdrop", 32'(step_valid), 32'd0);
        chk("rst_issue_count", 32'(step_count), 32'd0);
        chk("rst_issue_state", 32'(state_dbg),  32'd0);
        reset = 1'b0;
        base = edge_n;
        expect_step(2'b11, 8'd0, base + 5);
        drive(4'b1000, 1'b0, 4);
        chk("repress_early",  32'(step_valid), 32'd0);
        drive(4'b1000, 1'b0, 1);
        chk("repress_valid",  32'(step_valid), 32'd1);
        drive(4'b1000, 1'b1, 1);
        drive(4'b0000, 1'b0, 3);
        chk("repress_count",  32'(step_count), 32'd1);
        chk("repress_idle",   32'(state_dbg),  32'd0);

        drive(4'b0000, 1'b0, 2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
